// File: rtl/hilo_sched.sv
// Divide/HILO sequencer: launches the iterative divider, times its latency, strobes the HILO write
// and stalls HI/LO users in EX while a divide is in flight. HILO_SCHED_PERF_EN builds perf counters.
module hilo_sched #(
   parameter int DIV_CYCLES = 32,
   parameter int CNT_W      = 6
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        EX_Stall,
   input  logic        EX_Flush,
   input  logic        Op_Div,
   input  logic        Op_Divu,
   input  logic        Op_HiloAcc,
   input  logic        Div_Kill,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        Div_Start,
   output logic        Div_Signed,
   output logic [31:0] Div_A,
   output logic [31:0] Div_B,
   output logic        Hilo_Wr,
   output logic        Busy,
   output logic        ALU_Stall,
   output logic [31:0] Perf_Stalls,
   output logic [31:0] Perf_Divs
);

   typedef enum logic [1:0] {IDLE, BUSY, COMMIT} state_t;

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             start_n, wr_n, sgn_n;
   logic [31:0]      a_n, b_n;
   logic             issue;

   assign issue     = (Op_Div | Op_Divu) & ~EX_Stall & ~EX_Flush;
   assign Busy      = (state != IDLE);
   // Held through COMMIT so an EX-stage HILO write can never land on top of Hilo_Wr.
   assign ALU_Stall = Busy & (Op_Div | Op_Divu | Op_HiloAcc) & ~EX_Flush;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         Div_Start  <= 1'b0;
         Hilo_Wr    <= 1'b0;
         Div_Signed <= 1'b0;
         Div_A      <= '0;
         Div_B      <= '0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         Div_Start  <= start_n;
         Hilo_Wr    <= wr_n;
         Div_Signed <= sgn_n;
         Div_A      <= a_n;
         Div_B      <= b_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      start_n = 1'b0;
      wr_n    = 1'b0;
      sgn_n   = Div_Signed;
      a_n     = Div_A;
      b_n     = Div_B;
      case (state)
         IDLE: begin
            if (issue) begin
               a_n     = A;
               b_n     = B;
               sgn_n   = Op_Div;
               start_n = 1'b1;
               cnt_n   = CNT_W'(DIV_CYCLES - 1);
               state_n = BUSY;
            end
         end
         BUSY: begin
            // A kill on the final count still wins: nothing has been written yet.
            if (Div_Kill) begin
               cnt_n   = '0;
               state_n = IDLE;
            end else if (cnt == '0) begin
               wr_n    = 1'b1;
               state_n = COMMIT;
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         COMMIT:  state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

`ifdef HILO_SCHED_PERF_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         Perf_Stalls <= '0;
         Perf_Divs   <= '0;
      end else begin
         if (ALU_Stall && Perf_Stalls != 32'hFFFF_FFFF) Perf_Stalls <= Perf_Stalls + 1'b1;
         if (state == COMMIT && Perf_Divs != 32'hFFFF_FFFF) Perf_Divs <= Perf_Divs + 1'b1;
      end
   end
`else
   assign Perf_Stalls = '0;
   assign Perf_Divs   = '0;
`endif

endmodule

// File: tb/tb_hilo_sched.sv
// Bench for hilo_sched: vector table, directed timing sequences and random traffic
// checked against a timestamp-based model of the divide lifecycle.
module tb_hilo_sched;
   localparam int D = 32;
`ifdef HILO_SCHED_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic clock = 1'b0, reset = 1'b1;
   logic EX_Stall = 0, EX_Flush = 0, Op_Div = 0, Op_Divu = 0, Op_HiloAcc = 0, Div_Kill = 0;
   logic [31:0] A = '0, B = '0;
   logic Div_Start, Div_Signed, Hilo_Wr, Busy, ALU_Stall;
   logic [31:0] Div_A, Div_B, Perf_Stalls, Perf_Divs;

   hilo_sched #(.DIV_CYCLES(D), .CNT_W(6)) dut (
      .clock(clock), .reset(reset), .EX_Stall(EX_Stall), .EX_Flush(EX_Flush),
      .Op_Div(Op_Div), .Op_Divu(Op_Divu), .Op_HiloAcc(Op_HiloAcc), .Div_Kill(Div_Kill),
      .A(A), .B(B), .Div_Start(Div_Start), .Div_Signed(Div_Signed), .Div_A(Div_A),
      .Div_B(Div_B), .Hilo_Wr(Hilo_Wr), .Busy(Busy), .ALU_Stall(ALU_Stall),
      .Perf_Stalls(Perf_Stalls), .Perf_Divs(Perf_Divs));

   always #5 clock = ~clock;

   int checks = 0, errors = 0;
   int now;
   // Model: cycle in which the current divide was issued, or -1 when idle.
   int m_issue;
   logic [31:0] m_a, m_b, m_stalls, m_divs;
   logic m_sgn;
   int starts[$], wrs[$], stl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d got %h want %h", name, now, act, exp);
      end
   endtask

   task automatic model_reset();
      m_issue = -1; m_a = '0; m_b = '0; m_sgn = 1'b0; m_stalls = '0; m_divs = '0;
      starts.delete(); wrs.delete(); stl.delete();
   endtask

   // Called at a negedge; asserts reset between edges and checks outputs clear at once.
   task automatic do_reset();
      reset = 1'b1;
      {Op_Div, Op_Divu, Op_HiloAcc, EX_Stall, EX_Flush, Div_Kill} = '0;
      #1;
      chk("rst_busy", Busy, 0);       chk("rst_start", Div_Start, 0);
      chk("rst_wr", Hilo_Wr, 0);      chk("rst_a", Div_A, 0);
      chk("rst_b", Div_B, 0);         chk("rst_sgn", Div_Signed, 0);
      chk("rst_pstl", Perf_Stalls, 0); chk("rst_pdiv", Perf_Divs, 0);
      @(posedge clock); @(negedge clock);
      reset = 1'b0;
      model_reset();
      now = 0;
   endtask

   task automatic tick(input logic dv, dvu, acc, st, fl, kl, input logic [31:0] a, b);
      bit active, e_start, e_wr, e_stall;
      int rel;
      Op_Div = dv; Op_Divu = dvu; Op_HiloAcc = acc; EX_Stall = st; EX_Flush = fl; Div_Kill = kl;
      A = a; B = b;
      #1;
      active  = (m_issue >= 0);
      rel     = now - m_issue;
      e_start = active && rel == 1;
      e_wr    = active && rel == D + 1;
      e_stall = active && (dv | dvu | acc) && !fl;
      chk("busy", Busy, active);   chk("start", Div_Start, e_start);
      chk("hilo_wr", Hilo_Wr, e_wr); chk("alu_stall", ALU_Stall, e_stall);
      chk("div_a", Div_A, m_a);    chk("div_b", Div_B, m_b);
      chk("div_sgn", Div_Signed, m_sgn);
      chk("perf_stalls", Perf_Stalls, PERF ? m_stalls : 32'd0);
      chk("perf_divs", Perf_Divs, PERF ? m_divs : 32'd0);
      if (Div_Start) starts.push_back(now);
      if (Hilo_Wr) wrs.push_back(now);
      if (ALU_Stall) stl.push_back(now);
      if (e_stall) m_stalls++;
      if (active) begin
         if (rel == D + 1) begin m_issue = -1; m_divs++; end
         else if (kl) m_issue = -1;
      end else if ((dv | dvu) && !st && !fl) begin
         m_issue = now; m_a = a; m_b = b; m_sgn = dv;
      end
      @(posedge clock); @(negedge clock);
      now++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0, 32'hDEAD_0000 + i, 32'hBEEF);
   endtask

   typedef struct {
      logic dv, dvu, acc, st, fl, kl;
      logic [31:0] a, b;
      logic busy, start, stall;
   } vec_t;
   vec_t vt[12];

   initial begin
      // dv dvu acc st fl kl  a  b   busy start stall
      vt[0]  = '{1,0,0,1,0,0, 11, 2, 0,0,0};
      vt[1]  = '{1,0,0,1,0,0, 11, 2, 0,0,0};
      vt[2]  = '{1,0,0,1,0,0, 11, 2, 0,0,0};
      vt[3]  = '{1,0,0,0,0,0, 11, 2, 0,0,0};
      vt[4]  = '{0,0,0,0,0,0,  0, 0, 1,1,0};
      vt[5]  = '{0,0,1,0,0,0,  0, 0, 1,0,1};
      vt[6]  = '{0,0,0,0,0,1,  0, 0, 1,0,0};
      vt[7]  = '{0,1,0,0,0,0,  5, 3, 0,0,0};
      vt[8]  = '{0,0,1,0,1,0,  0, 0, 1,1,0};
      vt[9]  = '{1,1,0,0,0,1,  0, 0, 1,0,1};
      vt[10] = '{0,1,0,0,1,0,  9, 9, 0,0,0};
      vt[11] = '{0,0,0,0,0,0,  0, 0, 0,0,0};

      @(negedge clock);
      do_reset();

      // Table: EX_Stall hold-off, kill at third BUSY cycle, immediate re-issue, flush blocking issue.
      for (int i = 0; i < 12; i++) begin
         Op_Div = vt[i].dv; Op_Divu = vt[i].dvu; Op_HiloAcc = vt[i].acc;
         EX_Stall = vt[i].st; EX_Flush = vt[i].fl;
         #1;
         chk("vec_busy", Busy, vt[i].busy);
         chk("vec_start", Div_Start, vt[i].start);
         chk("vec_stall", ALU_Stall, vt[i].stall);
         chk("vec_wr", Hilo_Wr, 0);
         #1 tick(vt[i].dv, vt[i].dvu, vt[i].acc, vt[i].st, vt[i].fl, vt[i].kl, vt[i].a, vt[i].b);
      end
      chk("vec_ndivs", Perf_Divs, 0);
      chk("vec_starts", starts.size(), 2);
      chk("vec_latch_a", Div_A, 5);
      chk("vec_latch_sgn", Div_Signed, 0);

      // Single DIVU 100/7 issued at cycle 10.
      do_reset();
      idle(10);
      tick(0, 1, 0, 0, 0, 0, 100, 7);
      idle(36);
      chk("s1_nstart", starts.size(), 1);
      chk("s1_start", starts.size() > 0 ? starts[0] : -1, 11);
      chk("s1_nwr", wrs.size(), 1);
      chk("s1_wr", wrs.size() > 0 ? wrs[0] : -1, 43);
      chk("s1_a", Div_A, 100); chk("s1_b", Div_B, 7); chk("s1_sgn", Div_Signed, 0);

      // DIV at 10, MFLO sitting in EX from cycle 12.
      do_reset();
      idle(10);
      tick(1, 0, 0, 0, 0, 0, -32'sd50, 3);
      idle(1);
      for (int i = 0; i < 34; i++) tick(0, 0, 1, 0, 0, 0, 0, 0);
      chk("s2_nstall", stl.size(), 32);
      chk("s2_first", stl.size() > 0 ? stl[0] : -1, 12);
      chk("s2_last", stl.size() > 0 ? stl[stl.size()-1] : -1, 43);
      chk("s2_pstl", Perf_Stalls, PERF ? 32'd32 : 32'd0);
      chk("s2_pdiv", Perf_Divs, PERF ? 32'd1 : 32'd0);
      chk("s2_sgn", Div_Signed, 1);

      // Back-to-back: second DIV held in EX from cycle 11 until it issues at 44.
      do_reset();
      idle(10);
      for (int i = 10; i <= 44; i++) tick(1, 0, 0, 0, 0, 0, i, 1);
      idle(40);
      chk("b2b_nstart", starts.size(), 2);
      chk("b2b_start2", starts.size() > 1 ? starts[1] : -1, 45);
      chk("b2b_nwr", wrs.size(), 2);
      chk("b2b_wr1", wrs.size() > 0 ? wrs[0] : -1, 43);
      chk("b2b_wr2", wrs.size() > 1 ? wrs[1] : -1, 77);
      chk("b2b_a", Div_A, 44);

      // Async reset in the middle of BUSY, then no stray write.
      do_reset();
      idle(10);
      tick(0, 1, 0, 0, 0, 0, 77, 8);
      idle(10);
      chk("mid_busy", Busy, 1);
      do_reset();
      idle(40);
      chk("mid_nwr", wrs.size(), 0);

      // Random traffic against the model.
      do_reset();
      for (int i = 0; i < 3000; i++)
         tick($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0, $urandom_range(0, 30) == 0,
              $urandom, $urandom);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
